// File: rtl/mem_bus_arbiter.sv
// Round-robin arbiter and strobe sequencer for the shared main-memory bus.
// Requesters are scanned from a rotating pointer. The winner's request is
// latched, and then either a timed read/write strobe runs or a write into
// the protected region is rejected with an err pulse.
//
// Handshake: req[i] is a level request. The block samples it only while
// idle. Once the request is granted, gnt[i] stays high for the whole
// transaction, and done[i] pulses for exactly one cycle at the end (with
// err[i] on a rejected write). Changes to the requester inputs after the
// grant edge are ignored. The requester may drop req in the done cycle or
// keep it high to queue behind the other requesters.
module mem_bus_arbiter #(
  parameter int NREQ          = 3,
  parameter int DATA_W        = 256,
  parameter int ADDR_W        = 16,
  parameter int ACCESS_CYCLES = 2,
  parameter logic [ADDR_W-1:0] PROT_BASE = 'h8000
) (
  input  logic                     Clk,
  input  logic                     Reset,
  input  logic [NREQ-1:0]          req,
  input  logic [NREQ-1:0]          we,
  input  logic [NREQ*ADDR_W-1:0]   req_addr,
  input  logic [NREQ*DATA_W-1:0]   req_wdata,
  output logic [NREQ-1:0]          gnt,
  output logic [NREQ-1:0]          done,
  output logic [NREQ-1:0]          err,
  output logic [DATA_W-1:0]        rdata,
  output logic                     nRead,
  output logic                     nWrite,
  output logic [ADDR_W-1:0]        address,
  output logic [DATA_W-1:0]        ExeDataOut,
  input  logic [DATA_W-1:0]        MemDataOut,
  output logic [1:0]               state
);

  localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CNT_W = (ACCESS_CYCLES > 1) ? $clog2(ACCESS_CYCLES) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(ACCESS_CYCLES - 1);

  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] ACCESS    = 2'd1;
  localparam logic [1:0] DONE_ST   = 2'd2;

  logic [IDX_W-1:0]  ptr;
  logic [IDX_W-1:0]  cur;
  logic              cur_we;
  logic [CNT_W-1:0]  cnt;

  logic              found;
  logic [IDX_W-1:0]  win;
  logic [IDX_W:0]    scan;
  logic [NREQ-1:0]   win_oh;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic              sel_we;
  logic              prot_hit;

  // Rotating priority scan: first requester with req high, starting at ptr.
  always_comb begin
    found = 1'b0;
    win   = '0;
    scan  = '0;
    for (int i = 0; i < NREQ; i++) begin
      scan = {1'b0, ptr} + (IDX_W+1)'(i);
      if (scan >= (IDX_W+1)'(NREQ)) scan = scan - (IDX_W+1)'(NREQ);
      if (!found && req[scan[IDX_W-1:0]]) begin
        found = 1'b1;
        win   = scan[IDX_W-1:0];
      end
    end
    win_oh    = NREQ'(1) << win;
    sel_addr  = req_addr[win*ADDR_W +: ADDR_W];
    sel_wdata = req_wdata[win*DATA_W +: DATA_W];
    sel_we    = we[win];
    prot_hit  = sel_we && (sel_addr >= PROT_BASE);
  end

  // Transaction sequencer: IDLE -> ACCESS (strobe held) -> DONE -> IDLE.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state      <= IDLE;
      ptr        <= '0;
      cur        <= '0;
      cur_we     <= 1'b0;
      cnt        <= '0;
      gnt        <= '0;
      done       <= '0;
      err        <= '0;
      rdata      <= '0;
      nRead      <= 1'b1;
      nWrite     <= 1'b1;
      address    <= '0;
      ExeDataOut <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            cur    <= win;
            cur_we <= sel_we;
            cnt    <= '0;
            gnt    <= win_oh;
            if (prot_hit) begin
              // Rejected write: skip the strobe phase, memory untouched.
              state <= DONE_ST;
              done  <= win_oh;
              err   <= win_oh;
            end else begin
              state      <= ACCESS;
              address    <= sel_addr;
              nRead      <= sel_we;
              nWrite     <= ~sel_we;
              ExeDataOut <= sel_we ? sel_wdata : '0;
            end
          end
        end
        ACCESS: begin
          if (cnt == LAST_CNT) begin
            state      <= DONE_ST;
            nRead      <= 1'b1;
            nWrite     <= 1'b1;
            ExeDataOut <= '0;
            done       <= gnt;
            if (!cur_we) rdata <= MemDataOut;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE_ST: begin
          // The following IDLE cycle doubles as the bus turnaround.
          state <= IDLE;
          gnt   <= '0;
          done  <= '0;
          err   <= '0;
          ptr   <= (cur == IDX_W'(NREQ - 1)) ? '0 : cur + 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: directed scenarios followed by randomized
// traffic, all checked every cycle against a transaction-level model that
// predicts bus outputs from the grant time and the access latency.
module tb_mem_bus_arbiter;

  localparam int NREQ = 3;
  localparam int DW   = 256;
  localparam int AW   = 16;
  localparam int AC   = 2;

  // ---------------- clock / reset ----------------
  logic Clk = 1'b0;
  logic Reset;
  always #5 Clk = ~Clk;

  logic [NREQ-1:0]    req, we;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ*DW-1:0] req_wdata;
  logic [NREQ-1:0]    gnt, done, err;
  logic [DW-1:0]      rdata, ExeDataOut, MemDataOut;
  logic               nRead, nWrite;
  logic [AW-1:0]      address;
  logic [1:0]         dbg_state;

  mem_bus_arbiter #(
    .NREQ(NREQ), .DATA_W(DW), .ADDR_W(AW), .ACCESS_CYCLES(AC), .PROT_BASE(16'h8000)
  ) dut (
    .Clk(Clk), .Reset(Reset), .req(req), .we(we), .req_addr(req_addr),
    .req_wdata(req_wdata), .gnt(gnt), .done(done), .err(err), .rdata(rdata),
    .nRead(nRead), .nWrite(nWrite), .address(address), .ExeDataOut(ExeDataOut),
    .MemDataOut(MemDataOut), .state(dbg_state)
  );

  // ---------------- scoreboard ----------------
  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %0h, expected %0h", tag, $time, got, exp);
    end
  endtask

  // ---------------- memory device + reference memory ----------------
  logic [DW-1:0] dev_mem [int];
  logic [DW-1:0] ref_mem [int];
  bit            snap_w;
  logic [AW-1:0] snap_a;
  logic [DW-1:0] snap_d;

  function automatic logic [DW-1:0] dflt(input logic [AW-1:0] a);
    return {16{a ^ 16'h5A5A}};
  endfunction

  function automatic logic [DW-1:0] dev_rd(input logic [AW-1:0] a);
    return dev_mem.exists(int'(a)) ? dev_mem[int'(a)] : dflt(a);
  endfunction

  function automatic logic [DW-1:0] ref_rd(input logic [AW-1:0] a);
    return ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : dflt(a);
  endfunction

  // ---------------- reference model ----------------
  int            x = 0;        // edge counter
  bit            m_busy = 0, m_prot = 0, m_we = 0;
  int            m_start = 0, m_g = 0, m_ptr = 0;
  logic [AW-1:0] m_addr = '0, m_address = '0;
  logic [DW-1:0] m_wdata = '0, m_rdata = '0;

  logic [NREQ-1:0] e_gnt, e_done, e_err;
  logic            e_nread, e_nwrite;
  logic [DW-1:0]   e_exe;

  task automatic model_step();
    int d;
    int w;
    x++;
    // A write strobe low in the cycle before edge x lands in memory at edge x.
    if (m_busy && !m_prot && m_we && x > m_start && x <= m_start + AC)
      ref_mem[int'(m_addr)] = m_wdata;
    if (Reset) begin
      m_busy = 0; m_ptr = 0; m_address = '0; m_rdata = '0;
    end else if (m_busy) begin
      d = m_prot ? m_start : m_start + AC;
      if (!m_prot && !m_we && x == m_start + AC) m_rdata = ref_rd(m_addr);
      if (x == d + 1) begin
        m_busy = 0;
        m_ptr  = (m_g + 1) % NREQ;
      end
    end else if (req != '0) begin
      w = -1;
      for (int i = 0; i < NREQ; i++) begin
        int c;
        c = (m_ptr + i) % NREQ;
        if (w < 0 && req[c[1:0]]) w = c;
      end
      m_busy  = 1;
      m_start = x;
      m_g     = w;
      m_we    = we[w[1:0]];
      m_addr  = req_addr[w*AW +: AW];
      m_wdata = req_wdata[w*DW +: DW];
      m_prot  = m_we && (m_addr >= 16'h8000);
      if (!m_prot) m_address = m_addr;
    end
    e_gnt = '0; e_done = '0; e_err = '0;
    e_nread = 1'b1; e_nwrite = 1'b1; e_exe = '0;
    if (m_busy) begin
      d = m_prot ? m_start : m_start + AC;
      e_gnt = NREQ'(1) << m_g;
      if (x == d) e_done = NREQ'(1) << m_g;
      if (x == d && m_prot) e_err = NREQ'(1) << m_g;
      if (!m_prot && (x - m_start) < AC) begin
        if (m_we) begin
          e_nwrite = 1'b0;
          e_exe    = m_wdata;
        end else begin
          e_nread = 1'b0;
        end
      end
    end
  endtask

  // One clock: memory device update, model step, compare, memory response.
  task automatic cycle();
    @(posedge Clk);
    #1;
    if (snap_w) dev_mem[int'(snap_a)] = snap_d;
    model_step();
    check("gnt",        DW'(gnt),     DW'(e_gnt));
    check("done",       DW'(done),    DW'(e_done));
    check("err",        DW'(err),     DW'(e_err));
    check("nRead",      DW'(nRead),   DW'(e_nread));
    check("nWrite",     DW'(nWrite),  DW'(e_nwrite));
    check("address",    DW'(address), DW'(m_address));
    check("ExeDataOut", ExeDataOut,   e_exe);
    check("rdata",      rdata,        m_rdata);
    snap_w     = !nWrite;
    snap_a     = address;
    snap_d     = ExeDataOut;
    MemDataOut = dev_rd(address);
  endtask

  // ---------------- driver tasks ----------------
  task automatic set_req(input int i, input bit w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    we[i]                = w;
    req_addr[i*AW +: AW] = a;
    req_wdata[i*DW +: DW] = d;
  endtask

  task automatic serve(input int i, input bit w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    bit seen;
    seen = 0;
    set_req(i, w, a, d);
    req[i] = 1'b1;
    for (int n = 0; n < 12 && !seen; n++) begin
      cycle();
      if (done[i]) seen = 1;
    end
    req[i] = 1'b0;
    check("serve_done", DW'(seen), DW'(1'b1));
    cycle();
  endtask

  function automatic logic [AW-1:0] pick_addr();
    case ($urandom_range(0, 5))
      0:       return 16'h7FFF;
      1:       return 16'h8000;
      2:       return 16'hFFFF;
      3:       return 16'h8000 + 16'($urandom_range(0, 3));
      default: return 16'($urandom_range(0, 7));
    endcase
  endfunction

  task automatic drive_random();
    logic [DW-1:0] v;
    bit rq;
    for (int i = 0; i < NREQ; i++) begin
      rq = req[i];
      if (rq && done[i])                                rq = ($urandom_range(0, 2) == 0);
      else if (rq && gnt[i] && $urandom_range(0, 19) == 0) rq = 1'b0;
      else if (!rq)                                     rq = ($urandom_range(0, 2) == 0);
      req[i] = rq;
      for (int k = 0; k < DW / 32; k++) v[k*32 +: 32] = $urandom();
      set_req(i, 1'($urandom_range(0, 1)), pick_addr(), v);
    end
    Reset = ($urandom_range(0, 199) == 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    Reset = 1'b1; req = '0; we = '0; req_addr = '0; req_wdata = '0;
    MemDataOut = '0; snap_w = 0; snap_a = '0; snap_d = '0;
    dev_mem[4] = 256'd77;
    ref_mem[4] = 256'd77;
    cycle();
    cycle();
    Reset = 1'b0;
    cycle();

    // Single accesses, protection boundary and readback.
    serve(0, 1'b0, 16'h0004, '0);
    serve(1, 1'b1, 16'h2010, 256'h5);
    serve(0, 1'b0, 16'h2010, '0);
    serve(2, 1'b1, 16'h8000, '1);
    serve(0, 1'b0, 16'h8000, '0);
    serve(1, 1'b1, 16'h7FFF, 256'h9);
    serve(2, 1'b0, 16'h7FFF, '0);

    // Continuous contention from all requesters.
    set_req(0, 1'b0, 16'h0001, '0);
    set_req(1, 1'b1, 16'h0002, 256'hA1);
    set_req(2, 1'b0, 16'h0002, '0);
    req = 3'b111;
    repeat (16) cycle();
    req = '0;
    repeat (3) cycle();

    // Reset in the second access cycle of a write, then re-arbitrate.
    set_req(1, 1'b1, 16'h0100, 256'hAB);
    req = 3'b010;
    cycle();
    cycle();
    Reset = 1'b1;
    req = '0;
    cycle();
    Reset = 1'b0;
    set_req(2, 1'b0, 16'h0100, '0);
    req = 3'b110;
    repeat (10) cycle();
    req = '0;
    repeat (3) cycle();

    // Request dropped right after being sampled.
    set_req(0, 1'b0, 16'h0003, '0);
    req = 3'b001;
    cycle();
    req = '0;
    repeat (6) cycle();

    // Randomized traffic.
    repeat (1500) begin
      drive_random();
      cycle();
    end
    Reset = 1'b0;
    req = '0;
    repeat (6) cycle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
